// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, request type and one-hot helper for the writeback arbiter
package wb_pkg;

  localparam int WB_NUM_SRC    = 4;
  localparam int WB_NUM_PORT   = 2;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [4:0]               addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // Index of the set bit in a one-hot source vector (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [WB_NUM_SRC-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// rtl/wb_arb_pick.sv - rotating two-hit picker with same-address exclusion (collide_o under WB_ARBITER_PERF_EN)
module wb_arb_pick
  import wb_pkg::*;
(
  input  logic [WB_NUM_SRC-1:0]      valid_i,
  input  logic [WB_NUM_SRC-1:0][4:0] addr_i,
  input  logic [1:0]                 rr_ptr_i,
  output logic [WB_NUM_SRC-1:0]      grant0_o,
  output logic [WB_NUM_SRC-1:0]      grant1_o,
  output logic [WB_NUM_SRC-1:0]      r0_mask_o
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic                       collide_o
`endif
);

  logic [1:0] k;
  logic       found0;
  logic       found1;
  logic [4:0] a0;
`ifdef WB_ARBITER_PERF_EN
  logic       coll;
  assign collide_o = coll;
`endif

  // Walk sources from rr_ptr; first nonzero hit takes port 0, next distinct-address hit takes port 1.
  always_comb begin
    grant0_o = '0;
    grant1_o = '0;
    found0   = 1'b0;
    found1   = 1'b0;
    a0       = '0;
    k        = '0;
`ifdef WB_ARBITER_PERF_EN
    coll     = 1'b0;
`endif
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      k = rr_ptr_i + 2'(i);
      if (valid_i[k] && (addr_i[k] != '0)) begin
        if (!found0) begin
          grant0_o[k] = 1'b1;
          a0          = addr_i[k];
          found0      = 1'b1;
        end else if (!found1) begin
          if (addr_i[k] == a0) begin
`ifdef WB_ARBITER_PERF_EN
            coll = 1'b1;
`endif
          end else begin
            grant1_o[k] = 1'b1;
            found1      = 1'b1;
          end
        end
      end
    end
  end

  // Writes to r0 are dropped, so they are accepted immediately without a port.
  always_comb begin
    r0_mask_o = '0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      r0_mask_o[i] = valid_i[i] && (addr_i[i] == '0);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - 4-source to 2-port register-file writeback arbiter (perf counters under WB_ARBITER_PERF_EN)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = WB_NUM_SRC
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_SRC-1:0]                    src_valid_i,
  output logic [NUM_SRC-1:0]                    src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]               src_addr_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]    src_data_i,
  output logic [WB_NUM_PORT-1:0][4:0]           w_addr_o,
  output logic [WB_NUM_PORT-1:0][DATA_WIDTH-1:0] w_data_o,
  output logic [WB_NUM_PORT-1:0]                w_en_o
`ifdef WB_ARBITER_PERF_EN
  ,
  output logic [31:0]                           stall_cnt_o,
  output logic [31:0]                           collide_cnt_o
`endif
);

  logic [1:0]         rr_ptr;
  logic [NUM_SRC-1:0] g0;
  logic [NUM_SRC-1:0] g1;
  logic [NUM_SRC-1:0] r0_mask;
  logic [1:0]         idx0;
  logic [1:0]         idx1;
`ifdef WB_ARBITER_PERF_EN
  logic               collide;
`endif

  wb_arb_pick u_pick (
    .valid_i   (src_valid_i),
    .addr_i    (src_addr_i),
    .rr_ptr_i  (rr_ptr),
    .grant0_o  (g0),
    .grant1_o  (g1),
    .r0_mask_o (r0_mask)
`ifdef WB_ARBITER_PERF_EN
    ,
    .collide_o (collide)
`endif
  );

  assign idx0        = onehot_idx(g0);
  assign idx1        = onehot_idx(g1);
  assign src_ready_o = rst_n ? (g0 | g1 | r0_mask) : '0;

  // Register granted writes; idle ports keep their last address/data; pointer moves past the last grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en_o   <= '0;
      w_addr_o <= '0;
      w_data_o <= '0;
      rr_ptr   <= '0;
    end else begin
      w_en_o <= {|g1, |g0};
      if (|g0) begin
        w_addr_o[0] <= src_addr_i[idx0];
        w_data_o[0] <= src_data_i[idx0];
      end
      if (|g1) begin
        w_addr_o[1] <= src_addr_i[idx1];
        w_data_o[1] <= src_data_i[idx1];
      end
      if (|g1) begin
        rr_ptr <= idx1 + 2'd1;
      end else if (|g0) begin
        rr_ptr <= idx0 + 2'd1;
      end
    end
  end

`ifdef WB_ARBITER_PERF_EN
  logic [NUM_SRC-1:0] nz_pending;

  // Nonzero-address requests left waiting this cycle.
  always_comb begin
    nz_pending = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nz_pending[i] = src_valid_i[i] && (src_addr_i[i] != '0) && !src_ready_o[i];
    end
  end

  // Wrapping stall and same-address collision counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o   <= '0;
      collide_cnt_o <= '0;
    end else begin
      if (|nz_pending) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (collide) collide_cnt_o <= collide_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table-driven scoreboard bench for wb_arbiter (perf checks under WB_ARBITER_PERF_EN)
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [3:0]           src_valid;
  logic [3:0]           src_ready;
  logic [3:0][4:0]      src_addr;
  logic [3:0][31:0]     src_data;
  logic [1:0][4:0]      w_addr;
  logic [1:0][31:0]     w_data;
  logic [1:0]           w_en;
`ifdef WB_ARBITER_PERF_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          collide_cnt;
`endif

  wb_arbiter #(.DATA_WIDTH(32), .NUM_SRC(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_addr_i  (src_addr),
    .src_data_i  (src_data),
    .w_addr_o    (w_addr),
    .w_data_o    (w_data),
    .w_en_o      (w_en)
`ifdef WB_ARBITER_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt),
    .collide_cnt_o (collide_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][4:0] a;
    logic [3:0]      rdy;
    logic [1:0]      en;
    int              s0;
    int              s1;
    logic [1:0]      ptr;
    int              stall;
    int              coll;
  } vec_t;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  localparam int NV = 14;
  vec_t tv[NV];
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   exp_stall;
  int   exp_coll;

  function automatic logic [31:0] dfn(input int k, input logic [4:0] a);
    wb_req_t r;
    r.addr = a;
    r.data = 32'hAAAA_0000 | (32'(a) << 8) | 32'(k);
    return r.data;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0] rdy,
                              input logic [1:0] en, input int s0, input int s1, input logic [1:0] ptr,
                              input int stall, input int coll);
    vec_t t;
    t.v = v; t.a = a; t.rdy = rdy; t.en = en; t.s0 = s0; t.s1 = s1;
    t.ptr = ptr; t.stall = stall; t.coll = coll;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0][4:0] a);
    src_valid = v;
    for (int k = 0; k < 4; k++) begin
      src_addr[k] = a[k];
      src_data[k] = dfn(k, a[k]);
    end
  endtask

  initial begin
    exp_t e;
    bit   got;
    n_cmp = 0; n_bad = 0; exp_stall = 0; exp_coll = 0;

    //        valid    addrs {3,2,1,0}                  ready    en     s0  s1  ptr stl col
    tv[0]  = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5},     4'b0001, 2'b01, 0, -1, 2'd1, 0, 0);
    tv[1]  = mk(4'b1000, {5'd4, 5'd0, 5'd0, 5'd0},     4'b1000, 2'b01, 3, -1, 2'd0, 0, 0);
    tv[2]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},     4'b0011, 2'b11, 0,  1, 2'd2, 1, 0);
    tv[3]  = mk(4'b1100, {5'd4, 5'd3, 5'd0, 5'd0},     4'b1100, 2'b11, 2,  3, 2'd0, 0, 0);
    tv[4]  = mk(4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},     4'b0000, 2'b00, -1, -1, 2'd0, 0, 0);
    tv[5]  = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd6},     4'b0001, 2'b01, 0, -1, 2'd1, 0, 0);
    tv[6]  = mk(4'b0110, {5'd0, 5'd7, 5'd7, 5'd0},     4'b0010, 2'b01, 1, -1, 2'd2, 1, 1);
    tv[7]  = mk(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0},     4'b0100, 2'b01, 2, -1, 2'd3, 0, 0);
    tv[8]  = mk(4'b1000, {5'd2, 5'd0, 5'd0, 5'd0},     4'b1000, 2'b01, 3, -1, 2'd0, 0, 0);
    tv[9]  = mk(4'b1011, {5'd10, 5'd0, 5'd9, 5'd0},    4'b1011, 2'b11, 1,  3, 2'd0, 0, 0);
    tv[10] = mk(4'b0100, {5'd0, 5'd0, 5'd0, 5'd0},     4'b0100, 2'b00, -1, -1, 2'd0, 0, 0);
    tv[11] = mk(4'b1111, {5'd3, 5'd8, 5'd8, 5'd8},     4'b1001, 2'b11, 0,  3, 2'd0, 1, 1);
    tv[12] = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},     4'b0011, 2'b11, 0,  1, 2'd2, 1, 0);
    tv[13] = mk(4'b1011, {5'd4, 5'd0, 5'd2, 5'd1},     4'b1001, 2'b11, 3,  0, 2'd1, 1, 0);

    // reset with requests present: nothing accepted, everything cleared
    rst_n = 1'b0;
    drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", src_ready, 4'b0000);
    chk("reset_en", w_en, 2'b00);
    chk("reset_addr", w_addr, '0);
    chk("reset_data", w_data, '0);
    chk("reset_ptr", dut.rr_ptr, 2'd0);
`ifdef WB_ARBITER_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_collide_cnt", collide_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    drive(4'b0000, '0);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      drive(tv[r].v, tv[r].a);
      #1;
      chk($sformatf("v%0d_ready", r), src_ready, tv[r].rdy);
      e.en = tv[r].en;
      e.a0 = (tv[r].s0 >= 0) ? tv[r].a[tv[r].s0] : 5'd0;
      e.d0 = (tv[r].s0 >= 0) ? dfn(tv[r].s0, tv[r].a[tv[r].s0]) : 32'd0;
      e.a1 = (tv[r].s1 >= 0) ? tv[r].a[tv[r].s1] : 5'd0;
      e.d1 = (tv[r].s1 >= 0) ? dfn(tv[r].s1, tv[r].a[tv[r].s1]) : 32'd0;
      sb.push_back(e);
      exp_stall += tv[r].stall;
      exp_coll  += tv[r].coll;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL v%0d_scoreboard: got empty queue expected entry", r);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_en", r), w_en, e.en);
        if (e.en[0]) begin
          chk($sformatf("v%0d_addr0", r), w_addr[0], e.a0);
          chk($sformatf("v%0d_data0", r), w_data[0], e.d0);
        end
        if (e.en[1]) begin
          chk($sformatf("v%0d_addr1", r), w_addr[1], e.a1);
          chk($sformatf("v%0d_data1", r), w_data[1], e.d1);
        end
      end
      chk($sformatf("v%0d_ptr", r), dut.rr_ptr, tv[r].ptr);
`ifdef WB_ARBITER_PERF_EN
      chk($sformatf("v%0d_stall_cnt", r), stall_cnt, 32'(exp_stall));
      chk($sformatf("v%0d_collide_cnt", r), collide_cnt, 32'(exp_coll));
`endif
    end

    // fairness: src3 held while the others keep re-issuing
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      drive(4'b1111, {5'd12, 5'd3, 5'd2, 5'd1});
      #1;
      if (src_ready[3]) got = 1'b1;
      @(posedge clk);
    end
    chk("fairness_src3", got, 1'b1);

    // idle ports keep their last address and data
    @(negedge clk);
    drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd13});
    @(negedge clk);
    drive(4'b0000, '0);
    @(posedge clk);
    #1;
    chk("hold_en", w_en, 2'b00);
    chk("hold_addr0", w_addr[0], 5'd13);
    chk("hold_data0", w_data[0], dfn(0, 5'd13));

    // reset right after a grant
    @(negedge clk);
    drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd14});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", src_ready, 4'b0000);
    @(posedge clk);
    #1;
    chk("rst_mid_en", w_en, 2'b00);
    chk("rst_mid_addr0", w_addr[0], 5'd0);
    chk("rst_mid_data0", w_data[0], 32'd0);
    chk("rst_mid_ptr", dut.rr_ptr, 2'd0);
`ifdef WB_ARBITER_PERF_EN
    chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
    chk("rst_mid_collide_cnt", collide_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rep_ready", src_ready, 4'b0001);
    @(posedge clk);
    #1;
    chk("rst_rep_en", w_en, 2'b01);
    chk("rst_rep_addr0", w_addr[0], 5'd14);
    chk("rst_rep_ptr", dut.rr_ptr, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
